// File: rtl/halt_detector.sv
// halt_detector: sticky program-end detector that stops the core once PC reaches/passes PC_End.
// Latency: halt/overrun/cycle_count update on the rising edge that samples the trigger (1 cycle).
// Backpressure: none; halt is a level signal that gates PC update and fetch.
//
// Ports:
//   clk          - single clock, rising-edge state updates
//   reset        - asynchronous active-high reset, clears all state
//   PC_Curr      - current program counter (unsigned, PC_WIDTH bits)
//   PC_End       - address of the final instruction (unsigned, PC_WIDTH bits)
//   halt         - registered, sticky: end of program reached
//   overrun      - registered, sticky: halt caused by PC_Curr > PC_End
//   cycle_count  - edges taken up to and including the halting edge (saturating)

module halt_detector #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  PC_Curr,
  input  logic [PC_WIDTH-1:0]  PC_End,
  output logic                 halt,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  logic                 halt_q;
  logic                 overrun_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 hit;
  logic                 past_end;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Plain unsigned compare on the sampled value; a PC that has already
  // wrapped below PC_End is deliberately not treated as a hit.
  assign hit      = (PC_Curr >= PC_End);
  assign past_end = (PC_Curr != PC_End);

  // Counter saturates at all-ones so a program that never ends cannot
  // alias back to a small cycle count.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Once halted everything freezes until reset; inputs are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q    <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
    end else if (!halt_q) begin
      halt_q    <= hit;
      overrun_q <= hit && past_end;
      cnt_q     <= cnt_d;
    end
  end

  assign halt        = halt_q;
  assign overrun     = overrun_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_halt_detector.sv
// tb_halt_detector: randomized and directed stimulus against a behavioural model of halt_detector.
// Latency: model advances once per rising edge, outputs compared 1 time unit after the edge.
// Backpressure: none; the bench drives PC values freely every cycle.

module tb_halt_detector;

  logic        clk;
  logic        reset;
  logic [7:0]  PC_Curr;
  logic [7:0]  PC_End;
  logic        halt;
  logic        overrun;
  logic [15:0] cycle_count;

  halt_detector #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .PC_Curr     (PC_Curr),
    .PC_End      (PC_End),
    .halt        (halt),
    .overrun     (overrun),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: program state as plain integers.
  int m_halt = 0;
  int m_ovr  = 0;
  int m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".halt"},    {31'd0, halt},    m_halt);
    chk({tag, ".overrun"}, {31'd0, overrun}, m_ovr);
    chk({tag, ".count"},   {16'd0, cycle_count}, m_cnt);
  endtask

  // Drive inputs, take one rising edge, advance the model, compare.
  task automatic tick(input int pc, input int pe, input string tag);
    PC_Curr = pc[7:0];
    PC_End  = pe[7:0];
    @(posedge clk);
    if (reset) begin
      m_halt = 0; m_ovr = 0; m_cnt = 0;
    end else if (m_halt == 0) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (pc >= pe) begin
        m_halt = 1;
        m_ovr  = (pc > pe) ? 1 : 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_halt = 0; m_ovr = 0; m_cnt = 0;
    check_all(tag);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int pc;
    int pe;
    int steps;
    reset   = 1'b1;
    PC_Curr = '0;
    PC_End  = '0;
    #1;
    check_all("reset_init");

    // Reset held through two sweeps.
    for (int i = 0; i <= 254; i++) tick(i, 250, "rst_hold_a");
    for (int i = 0; i <= 254; i++) tick(i, 120, "rst_hold_b");

    // Exact match at 250.
    reset = 1'b0;
    for (int i = 0; i <= 254; i++) begin
      tick(i, 250, "exact");
      if (i == 250) begin
        chk("exact.halt_at_250", {31'd0, halt}, 1);
        chk("exact.ovr_at_250", {31'd0, overrun}, 0);
        chk("exact.cnt_at_250", {16'd0, cycle_count}, 251);
      end
    end
    chk("exact.cnt_hold", {16'd0, cycle_count}, 251);

    // Mid-run reset while halted, then count to 120.
    pulse_reset("midrst");
    for (int i = 0; i <= 125; i++) tick(i, 120, "midrst_run");
    chk("midrst.cnt", {16'd0, cycle_count}, 121);
    chk("midrst.ovr", {31'd0, overrun}, 0);

    // Jump past end.
    pulse_reset("jump_rst");
    tick(0, 120, "jump");
    tick(50, 120, "jump");
    tick(130, 120, "jump");
    chk("jump.halt", {31'd0, halt}, 1);
    chk("jump.ovr", {31'd0, overrun}, 1);
    chk("jump.cnt", {16'd0, cycle_count}, 3);
    tick(5, 200, "jump_hold");

    // PC_End = 0 halts on the first edge.
    pulse_reset("end0_rst");
    tick(0, 0, "end0");
    chk("end0.halt", {31'd0, halt}, 1);
    chk("end0.ovr", {31'd0, overrun}, 0);
    chk("end0.cnt", {16'd0, cycle_count}, 1);

    // PC_End = 255: only the all-ones sample halts; wrap afterwards ignored.
    pulse_reset("end255_rst");
    for (int i = 0; i <= 260; i++) begin
      tick(i % 256, 255, "end255");
      if (i == 254) chk("end255.no_halt_254", {31'd0, halt}, 0);
    end
    chk("end255.halt", {31'd0, halt}, 1);
    chk("end255.ovr", {31'd0, overrun}, 0);
    chk("end255.cnt", {16'd0, cycle_count}, 256);

    // Wrapped sample below end never halts.
    pulse_reset("wrap_rst");
    tick(200, 210, "wrap");
    tick(5, 210, "wrap");
    chk("wrap.no_halt", {31'd0, halt}, 0);

    // Randomized runs with occasional end changes and PC jumps.
    for (int r = 0; r < 30; r++) begin
      pulse_reset("rand_rst");
      pe = $urandom_range(0, 255);
      pc = $urandom_range(0, 40);
      steps = $urandom_range(5, 300);
      for (int s = 0; s < steps; s++) begin
        tick(pc, pe, "rand");
        if ($urandom_range(0, 15) == 0) pe = $urandom_range(0, 255);
        if ($urandom_range(0, 20) == 0) pc = $urandom_range(0, 255);
        else pc = (pc + $urandom_range(0, 3)) % 256;
      end
    end

    // Saturation: never halts, counter pins at all-ones.
    pulse_reset("sat_rst");
    for (int i = 0; i < 65540; i++) tick(0, 255, "sat");
    chk("sat.cnt", {16'd0, cycle_count}, 32'h0000FFFF);
    chk("sat.halt", {31'd0, halt}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
